wtch_datapath: RTL

WTCH_DATAPATH -- requirements
Module: wtch_datapath

---
 rtl/wtch_pkg.sv | 21 ++
 rtl/wtch_if.sv | 25 ++
 rtl/wtch_mod_counter.sv | 28 ++
 rtl/wtch_datapath.sv | 112 +++++++++++
 4 files changed

// File: rtl/wtch_pkg.sv
// Shared constants and types for the stopwatch/clock datapath.
// Field limits and widths are used by the top and the testbench.
package wtch_pkg;

    localparam int CS_MAX   = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int CS_W   = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    typedef enum logic [1:0] {
        CAL_NONE = 2'd0,
        CAL_UP   = 2'd1,
        CAL_DN   = 2'd2
    } cal_cmd_e;

endpackage

// File: rtl/wtch_if.sv
// Control and time-field bundle between the datapath and its user.
interface wtch_if;
    import wtch_pkg::*;

    logic              run;
    logic              up;
    logic              dn;
    logic              calib_right;
    logic [CS_W-1:0]   cs;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
    logic              tick;

    modport master (
        output run, up, dn, calib_right,
        input  cs, sec, min, hour, tick
    );

    modport slave (
        input  run, up, dn, calib_right,
        output cs, sec, min, hour, tick
    );

endinterface

// File: rtl/wtch_mod_counter.sv
// Modulo-(MAX+1) up/down counter; carry flags the MAX->0 wrap on an increment.
module wtch_mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc && !dec) begin
            value <= (value == MAX_V) ? '0 : value + W'(1);
        end else if (dec && !inc) begin
            value <= (value == '0) ? MAX_V : value - W'(1);
        end
    end

    assign carry = inc && !dec && (value == MAX_V);

endmodule

// File: rtl/wtch_datapath.sv
// Centisecond time base with cs/sec/min(/hour) counters and sec/min calibration.
// Define WTCH_HOUR_EN to build the hour counter; otherwise hour reads 0.
module wtch_datapath
    import wtch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic   clk,
    input  logic   rst,
    wtch_if.slave  bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PSC_TC = PW'(DIV - 1);

    logic [PW-1:0] psc;
    logic          tick_int;
    logic          adv;
    cal_cmd_e      cmd;
    logic          cal_up;
    logic          cal_dn;

    logic [CS_W-1:0]  cs_val;
    logic [SEC_W-1:0] sec_val;
    logic [MIN_W-1:0] min_val;
    logic             cs_carry;
    logic             sec_carry;
    logic             min_carry;

    // Prescaler freezes while paused so resuming keeps the tick phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
        end else if (bus.run) begin
            psc <= (psc == PSC_TC) ? '0 : psc + PW'(1);
        end
    end

    assign tick_int = bus.run && (psc == PSC_TC);

    always_comb begin
        cmd = CAL_NONE;
        if (bus.up && !bus.dn) begin
            cmd = CAL_UP;
        end else if (bus.dn && !bus.up) begin
            cmd = CAL_DN;
        end
    end

    assign cal_up = (cmd == CAL_UP);
    assign cal_dn = (cmd == CAL_DN);

    // Any calibration request in a tick cycle swallows that tick.
    assign adv = tick_int && !(bus.up || bus.dn);

    wtch_mod_counter #(.MAX(CS_MAX), .W(CS_W)) u_cs (
        .clk   (clk),
        .rst   (rst),
        .inc   (adv),
        .dec   (1'b0),
        .value (cs_val),
        .carry (cs_carry)
    );

    wtch_mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (cs_carry || (cal_up && bus.calib_right)),
        .dec   (cal_dn && bus.calib_right),
        .value (sec_val),
        .carry (sec_carry)
    );

    // sec_carry from a calibration wrap must not ripple into min.
    wtch_mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   ((sec_carry && adv) || (cal_up && !bus.calib_right)),
        .dec   (cal_dn && !bus.calib_right),
        .value (min_val),
        .carry (min_carry)
    );

`ifdef WTCH_HOUR_EN
    logic [HOUR_W-1:0] hour_val;
    logic              unused_hour_carry;

    wtch_mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_carry && adv),
        .dec   (1'b0),
        .value (hour_val),
        .carry (unused_hour_carry)
    );

    assign bus.hour = hour_val;
`else
    logic unused_min_carry;

    assign unused_min_carry = min_carry;
    assign bus.hour         = '0;
`endif

    assign bus.cs   = cs_val;
    assign bus.sec  = sec_val;
    assign bus.min  = min_val;
    assign bus.tick = tick_int;

endmodule
